// File: rtl/easy_fifo_pkg.sv
// Shared types and helpers for the easy_fifo AXIS stages.
package easy_fifo_pkg;

    // Packetizer state: EMPTY = hold register empty, HOLD = one beat held,
    // FINAL = held beat must leave as the last beat of the packet.
    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        FINAL
    } pktz_state_t;

    // Bits needed to represent the value n (at least 1).
    function automatic int unsigned clog2p1(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(64'(n) + 64'd1);
    endfunction

endpackage

// File: rtl/easy_axis_out_reg.sv
// Single-entry AXIS output register slice: loads {data,last} when told to,
// holds it stable until the downstream accepts it.
module easy_axis_out_reg #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_last,
    input  logic              m_tready,
    output logic              free,
    output logic [DWIDTH-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid
);

    logic [DWIDTH-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    assign free     = !valid_q || m_tready;
    assign m_tdata  = data_q;
    assign m_tlast  = last_q;
    assign m_tvalid = valid_q;

    // Next contents: a load (only issued while free) wins over a plain drain.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            last_d  = load_last;
            valid_d = 1'b1;
        end else if (m_tready) begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/easy_axis_packetizer.sv
// AXIS packetizer: frames an unframed beat stream into packets closed by
// MAX_BEATS, an idle TIMEOUT or a flush pulse. One beat is held back so tlast
// can be attached after the fact.
// Optional: define EASY_PACKETIZER_STATS_EN for pkt_count/timeout_count outputs.
module easy_axis_packetizer
    import easy_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned MAX_BEATS = 64,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    input  logic              flush
`ifdef EASY_PACKETIZER_STATS_EN
   ,output logic [31:0]       pkt_count,
    output logic [31:0]       timeout_count
`endif
);

    localparam int unsigned      CNT_W      = clog2p1(MAX_BEATS);
    localparam int unsigned      TMR_W      = clog2p1(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(MAX_BEATS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    pktz_state_t       state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d, beat_inc;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DWIDTH-1:0] hold_q, hold_d;

    logic              o_free;
    logic              o_load;
    logic [DWIDTH-1:0] o_data;
    logic              o_last;
    logic              accept;
    logic              timeout_hit;

    assign s_axis_tready = rst && o_free && (state_q != FINAL);
    assign accept        = s_axis_tvalid && s_axis_tready;

    easy_axis_out_reg #(
        .DWIDTH(DWIDTH)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (o_load),
        .load_data(o_data),
        .load_last(o_last),
        .m_tready (m_axis_tready),
        .free     (o_free),
        .m_tdata  (m_axis_tdata),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid)
    );

    // Next-state, hold-register and output-load decisions.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        o_load      = 1'b0;
        o_data      = hold_q;
        o_last      = 1'b0;
        timeout_hit = 1'b0;
        beat_inc    = beat_cnt_q + CNT_W'(1);
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (beat_cnt_q == LAST_IDX) begin
                        // Packet-completing beat bypasses the hold register.
                        o_load     = 1'b1;
                        o_data     = s_axis_tdata;
                        o_last     = 1'b1;
                        beat_cnt_d = '0;
                    end else begin
                        hold_d  = s_axis_tdata;
                        state_d = HOLD;
                        timer_d = '0;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    // A new beat proves the held one is not last; flush is dropped.
                    o_load     = 1'b1;
                    o_data     = hold_q;
                    beat_cnt_d = beat_inc;
                    hold_d     = s_axis_tdata;
                    timer_d    = '0;
                    if (beat_inc == LAST_IDX) begin
                        state_d = FINAL;
                    end
                end else begin
                    if (timer_q != TMR_MAX) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    timeout_hit = TIMEOUT_EN && (timer_q == TMR_MAX);
                    if (timeout_hit || flush) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                if (o_free) begin
                    o_load     = 1'b1;
                    o_data     = hold_q;
                    o_last     = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Control and hold-register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            beat_cnt_q <= '0;
            timer_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
        end
    end

`ifdef EASY_PACKETIZER_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] timeout_count_q, timeout_count_d;

    assign pkt_count     = pkt_count_q;
    assign timeout_count = timeout_count_q;

    // Wrapping event counters: accepted last beats and timeout-caused closes.
    always_comb begin
        pkt_count_d     = pkt_count_q;
        timeout_count_d = timeout_count_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        if (timeout_hit) begin
            timeout_count_d = timeout_count_q + 32'd1;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_count_q     <= '0;
            timeout_count_q <= '0;
        end else begin
            pkt_count_q     <= pkt_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_easy_axis_packetizer.sv
// Directed bench for easy_axis_packetizer: three instances
// (a: MAX_BEATS=4/TIMEOUT=0, b: MAX_BEATS=4/TIMEOUT=10, c: MAX_BEATS=1/TIMEOUT=0).
module tb_easy_axis_packetizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vecs = 0;
    int   errs = 0;

    logic [31:0] a_s_tdata, b_s_tdata, c_s_tdata;
    logic        a_s_tvalid, b_s_tvalid, c_s_tvalid;
    logic        a_s_tready, b_s_tready, c_s_tready;
    logic [31:0] a_m_tdata, b_m_tdata, c_m_tdata;
    logic        a_m_tvalid, b_m_tvalid, c_m_tvalid;
    logic        a_m_tready, b_m_tready, c_m_tready;
    logic        a_m_tlast, b_m_tlast, c_m_tlast;
    logic        a_flush, b_flush, c_flush;
`ifdef EASY_PACKETIZER_STATS_EN
    logic [31:0] a_pkt, a_to, b_pkt, b_to, c_pkt, c_to;
`endif

    easy_axis_packetizer #(.DWIDTH(32), .MAX_BEATS(4), .TIMEOUT(0)) u_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
        .m_axis_tlast(a_m_tlast), .flush(a_flush)
`ifdef EASY_PACKETIZER_STATS_EN
       ,.pkt_count(a_pkt), .timeout_count(a_to)
`endif
    );

    easy_axis_packetizer #(.DWIDTH(32), .MAX_BEATS(4), .TIMEOUT(10)) u_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .m_axis_tlast(b_m_tlast), .flush(b_flush)
`ifdef EASY_PACKETIZER_STATS_EN
       ,.pkt_count(b_pkt), .timeout_count(b_to)
`endif
    );

    easy_axis_packetizer #(.DWIDTH(32), .MAX_BEATS(1), .TIMEOUT(0)) u_c (
        .clk(clk), .rst(rst),
        .s_axis_tdata(c_s_tdata), .s_axis_tvalid(c_s_tvalid), .s_axis_tready(c_s_tready),
        .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
        .m_axis_tlast(c_m_tlast), .flush(c_flush)
`ifdef EASY_PACKETIZER_STATS_EN
       ,.pkt_count(c_pkt), .timeout_count(c_to)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted output beats {tlast, tdata}, captured at the negedge before the accepting edge.
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic [32:0] qc[$];
    always @(negedge clk) begin
        if (rst) begin
            if (a_m_tvalid && a_m_tready) qa.push_back({a_m_tlast, a_m_tdata});
            if (b_m_tvalid && b_m_tready) qb.push_back({b_m_tlast, b_m_tdata});
            if (c_m_tvalid && c_m_tready) qc.push_back({c_m_tlast, c_m_tdata});
        end
    end

    // Instance a: output must stay valid and unchanged across a stall.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [31:0] pd = '0;
    always @(negedge clk) begin
        if (rst && pv && !pr) begin
            check("stall_valid", a_m_tvalid, 1);
            check("stall_beat", {a_m_tlast, a_m_tdata}, {pl, pd});
        end
        pv = rst && a_m_tvalid;
        pr = a_m_tready;
        pl = a_m_tlast;
        pd = a_m_tdata;
    end

    // Present one beat and wait (bounded) for it to be taken; valid stays up.
    task automatic send(input int which, input logic [31:0] d);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        case (which)
            0: begin a_s_tdata = d; a_s_tvalid = 1'b1; end
            1: begin b_s_tdata = d; b_s_tvalid = 1'b1; end
            default: begin c_s_tdata = d; c_s_tvalid = 1'b1; end
        endcase
        do begin
            @(negedge clk);
            acc = (which == 0) ? a_s_tready : (which == 1) ? b_s_tready : c_s_tready;
            tick();
            n++;
        end while (!acc && n < 50);
        check("send_accept", acc, 1);
    endtask

    // Compare n captured beats to first.. with tlast every mb-th beat, then clear.
    task automatic check_q(input string tag, input int which, input logic [31:0] first,
                           input int n, input int mb);
        logic [32:0] q[$];
        logic [32:0] e;
        if (which == 0) begin q = qa; qa.delete(); end
        else if (which == 1) begin q = qb; qb.delete(); end
        else begin q = qc; qc.delete(); end
        check({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            e = {((i % mb) == (mb - 1)), first + 32'(i)};
            check(tag, q[i], e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        a_s_tdata = '0; b_s_tdata = '0; c_s_tdata = '0;
        a_s_tvalid = 1'b0; b_s_tvalid = 1'b0; c_s_tvalid = 1'b0;
        a_m_tready = 1'b1; b_m_tready = 1'b1; c_m_tready = 1'b1;
        a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_valid", a_m_tvalid, 0);
        check("rst_last", a_m_tlast, 0);
        check("rst_data", a_m_tdata, 0);
        check("rst_sready", a_s_tready, 0);
        check("rst_c_sready", c_s_tready, 0);
        rst = 1'b1;
        tick();

        // Back-to-back beats 0..7, tlast on 3 and 7
        for (int i = 0; i < 8; i++) send(0, 32'(i));
        a_s_tvalid = 1'b0;
        repeat (6) tick();
        check_q("b2b", 0, 32'd0, 8, 4);

        // Timeout: close decided on the 10th idle edge, beat loads on the next
        send(1, 32'd0);
        send(1, 32'd1);
        b_s_tvalid = 1'b0;
        repeat (10) tick();
        check("to_early_valid", b_m_tvalid, 0);
        tick();
        check("to_valid", b_m_tvalid, 1);
        check("to_last", b_m_tlast, 1);
        check("to_data", b_m_tdata, 1);
        tick();
        check_q("to_pkt", 1, 32'd0, 2, 2);
`ifdef EASY_PACKETIZER_STATS_EN
        check("to_stat_pkt", b_pkt, 1);
        check("to_stat_to", b_to, 1);
`endif

        // Flush closes the packet; the next packet counts from zero
        send(0, 32'd10);
        send(0, 32'd11);
        a_s_tvalid = 1'b0;
        repeat (5) tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl_early_valid", a_m_tvalid, 0);
        tick();
        check("fl_valid", a_m_tvalid, 1);
        check("fl_last", a_m_tlast, 1);
        check("fl_data", a_m_tdata, 11);
        tick();
        check_q("fl_pkt", 0, 32'd10, 2, 2);
        for (int i = 0; i < 4; i++) send(0, 32'(20 + i));
        a_s_tvalid = 1'b0;
        repeat (6) tick();
        check_q("fl_next", 0, 32'd20, 4, 4);

        // Toggling backpressure with continuous input
        fork
            begin
                for (int i = 0; i < 8; i++) send(0, 32'(30 + i));
                a_s_tvalid = 1'b0;
            end
            begin
                repeat (40) begin
                    tick();
                    a_m_tready = ~a_m_tready;
                end
            end
        join
        a_m_tready = 1'b1;
        repeat (6) tick();
        check_q("bp", 0, 32'd30, 8, 4);

        // MAX_BEATS=1: always ready, every beat last
        c_s_tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c_s_tdata = 32'(40 + i);
            @(negedge clk);
            check("mb1_sready", c_s_tready, 1);
            tick();
        end
        c_s_tvalid = 1'b0;
        repeat (3) tick();
        check_q("mb1", 2, 32'd40, 6, 1);

        // Reset while a beat is held and another is stalled in the output
        send(0, 32'd50);
        send(0, 32'd51);
        send(0, 32'd52);
        a_m_tready = 1'b0;
        a_s_tvalid = 1'b0;
        rst = 1'b0;
        tick();
        a_m_tready = 1'b1;
        check("mr_valid", a_m_tvalid, 0);
        check("mr_last", a_m_tlast, 0);
        check("mr_data", a_m_tdata, 0);
        check("mr_sready", a_s_tready, 0);
`ifdef EASY_PACKETIZER_STATS_EN
        check("mr_stat_pkt", a_pkt, 0);
        check("mr_stat_to", b_to, 0);
`endif
        rst = 1'b1;
        tick();
        qa.delete();
        for (int i = 0; i < 4; i++) send(0, 32'(60 + i));
        a_s_tvalid = 1'b0;
        repeat (6) tick();
        check_q("mr_pkt", 0, 32'd60, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
